// File: rtl/mux_n_w_reg_pkg.sv
// Shared definitions for the N-channel registered multiplexer: selection modes,
// output-slot state encoding and the select-width helper.
package mux_n_w_reg_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Width of sel/grant; a 2-channel mux still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_w_reg_if.sv
// Bundle of the channel-side and consumer-side handshake signals of mux_n_w_reg.
// Channel i occupies in_data[i*WIDTH +: WIDTH].
interface mux_n_w_reg_if
  import mux_n_w_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = sel_width(N);

  // Handshake: a word moves on a cycle where valid and ready are both high at the
  // rising edge. A source holds valid and data stable until it sees ready; in_ready
  // never depends on in_data, and out_valid only drops after out_ready.
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    grant;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, grant
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, grant
  );

endinterface

// File: rtl/mux_n_w_reg_rr_arbiter.sv
// Round-robin channel picker: first requesting channel after the last granted one,
// scanning upward with wrap from N-1 to 0.
module mux_n_w_reg_rr_arbiter
  import mux_n_w_reg_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] last_i,
  input  logic            en_i,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_any_o
);

  logic found;

  // Offset k=1 has the highest priority, so the previous winner is considered last.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      for (int c = 0; c < N; c++) begin
        if (!found && req_i[c] && (((int'(last_i) + k) % N) == c)) begin
          found     = 1'b1;
          gnt_idx_o = SELW'(c);
        end
      end
    end
  end

  assign gnt_any_o = found & en_i;

endmodule

// File: rtl/mux_n_w_reg.sv
// N-channel, WIDTH-bit multiplexer with one output register slot, selecting a channel
// either by an external sel or round-robin over valid channels.
module mux_n_w_reg
  import mux_n_w_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = MODE_SEL
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_n_w_reg_if.slave bus,
  output slot_state_e  state_o
);
  localparam int SELW = sel_width(N);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  chosen;
  logic             chosen_valid;
  logic             can_load;
  logic             accept;
  logic [WIDTH-1:0] slice [N];
  logic [WIDTH-1:0] chosen_data;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slice[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // The slot takes a new word when empty or when its current word leaves this cycle.
  assign can_load = rst_n & ((state_q == SLOT_EMPTY) | bus.out_ready);
  assign accept   = can_load & chosen_valid;

  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] last_q, last_d;
    logic            gnt_any;

    mux_n_w_reg_rr_arbiter #(.N(N)) u_arb (
      .req_i     (bus.in_valid),
      .last_i    (last_q),
      .en_i      (can_load),
      .gnt_idx_o (chosen),
      .gnt_any_o (gnt_any)
    );

    assign chosen_valid = gnt_any;
    assign last_d       = accept ? chosen : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_q <= SELW'(N - 1);
      end else begin
        last_q <= last_d;
      end
    end
  end else begin : g_sel
    assign chosen = bus.sel;

    // A sel value with no matching channel leaves chosen_valid low.
    always_comb begin
      chosen_valid = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (bus.sel == SELW'(c)) chosen_valid = bus.in_valid[c];
      end
    end
  end

  always_comb begin
    chosen_data = '0;
    for (int c = 0; c < N; c++) begin
      if (chosen == SELW'(c)) chosen_data = slice[c];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign bus.in_ready[i] = accept & (chosen == SELW'(i));
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (accept) begin
          state_d = SLOT_FULL;
          data_d  = chosen_data;
          grant_d = chosen;
        end
      end
      SLOT_FULL: begin
        if (accept) begin
          data_d  = chosen_data;
          grant_d = chosen;
        end else if (bus.out_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == SLOT_FULL);
  assign bus.grant     = grant_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mux_n_w_reg.sv
// Bench for mux_n_w_reg: five instances (N=4 sel, N=4 round-robin, N=2 sel, N=3 sel,
// N=3 round-robin) driven from per-instance stimulus and checked against a slot model.
module tb_mux_n_w_reg;
  import mux_n_w_reg_pkg::*;

  localparam int W  = 8;
  localparam int ND = 5;

  function automatic int n_of(input int d);
    case (d)
      0, 1:    return 4;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int mode_of(input int d);
    return (d == 1 || d == 4) ? MODE_RR : MODE_SEL;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance stimulus and observation ----------------
  logic [4*W-1:0] in_data_s   [ND];
  logic [3:0]     in_valid_s  [ND];
  logic [1:0]     sel_s       [ND];
  logic           out_ready_s [ND];
  logic [3:0]     obs_ready   [ND];
  logic [W-1:0]   obs_data    [ND];
  logic           obs_valid   [ND];
  logic [1:0]     obs_grant   [ND];
  slot_state_e    obs_state   [ND];

  mux_n_w_reg_if #(.WIDTH(W), .N(4)) if0 ();
  mux_n_w_reg_if #(.WIDTH(W), .N(4)) if1 ();
  mux_n_w_reg_if #(.WIDTH(W), .N(2)) if2 ();
  mux_n_w_reg_if #(.WIDTH(W), .N(3)) if3 ();
  mux_n_w_reg_if #(.WIDTH(W), .N(3)) if4 ();

  assign if0.in_data = in_data_s[0];       assign if0.in_valid = in_valid_s[0];
  assign if0.sel = sel_s[0];               assign if0.out_ready = out_ready_s[0];
  assign obs_ready[0] = if0.in_ready;      assign obs_data[0] = if0.out_data;
  assign obs_valid[0] = if0.out_valid;     assign obs_grant[0] = if0.grant;

  assign if1.in_data = in_data_s[1];       assign if1.in_valid = in_valid_s[1];
  assign if1.sel = sel_s[1];               assign if1.out_ready = out_ready_s[1];
  assign obs_ready[1] = if1.in_ready;      assign obs_data[1] = if1.out_data;
  assign obs_valid[1] = if1.out_valid;     assign obs_grant[1] = if1.grant;

  assign if2.in_data = in_data_s[2][2*W-1:0];  assign if2.in_valid = in_valid_s[2][1:0];
  assign if2.sel = sel_s[2][0];                assign if2.out_ready = out_ready_s[2];
  assign obs_ready[2] = {2'b00, if2.in_ready}; assign obs_data[2] = if2.out_data;
  assign obs_valid[2] = if2.out_valid;         assign obs_grant[2] = {1'b0, if2.grant};

  assign if3.in_data = in_data_s[3][3*W-1:0];  assign if3.in_valid = in_valid_s[3][2:0];
  assign if3.sel = sel_s[3];                   assign if3.out_ready = out_ready_s[3];
  assign obs_ready[3] = {1'b0, if3.in_ready};  assign obs_data[3] = if3.out_data;
  assign obs_valid[3] = if3.out_valid;         assign obs_grant[3] = if3.grant;

  assign if4.in_data = in_data_s[4][3*W-1:0];  assign if4.in_valid = in_valid_s[4][2:0];
  assign if4.sel = sel_s[4];                   assign if4.out_ready = out_ready_s[4];
  assign obs_ready[4] = {1'b0, if4.in_ready};  assign obs_data[4] = if4.out_data;
  assign obs_valid[4] = if4.out_valid;         assign obs_grant[4] = if4.grant;

  mux_n_w_reg #(.WIDTH(W), .N(4), .MODE(MODE_SEL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .state_o(obs_state[0]));
  mux_n_w_reg #(.WIDTH(W), .N(4), .MODE(MODE_RR)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .state_o(obs_state[1]));
  mux_n_w_reg #(.WIDTH(W), .N(2), .MODE(MODE_SEL)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .state_o(obs_state[2]));
  mux_n_w_reg #(.WIDTH(W), .N(3), .MODE(MODE_SEL)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .state_o(obs_state[3]));
  mux_n_w_reg #(.WIDTH(W), .N(3), .MODE(MODE_RR)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .state_o(obs_state[4]));

  // ---------------- scoreboard state ----------------
  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_q[$];   // {instance[3:0], grant[3:0], data[7:0]}
  bit          full_m [ND];
  int          last_m [ND];
  logic [3:0]  acc_m  [ND];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic purge(input int d);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][15:12] == 4'(d)) exp_q.delete(i);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_all(input logic [3:0] v, input logic [31:0] data,
                         input logic [1:0] s, input logic ordy);
    for (int d = 0; d < ND; d++) begin
      in_valid_s[d]  = v;
      in_data_s[d]   = data;
      sel_s[d]       = s;
      out_ready_s[d] = ordy;
    end
  endtask

  // Called right after the falling edge once inputs are applied: checks the
  // combinational response and predicts what the next rising edge will capture.
  task automatic eval();
    int         n;
    int         c;
    bit         cv;
    bit         can;
    logic [3:0] er;
    logic [W-1:0] word;
    #1;
    for (int d = 0; d < ND; d++) begin
      n = n_of(d);
      if (!rst_n) begin
        full_m[d] = 1'b0;
        last_m[d] = n - 1;
        purge(d);
      end
      check($sformatf("out_valid[%0d]", d), 32'(obs_valid[d]), 32'(full_m[d]));
      check($sformatf("state[%0d]", d), 32'(obs_state[d]), 32'(full_m[d]));
      can = rst_n && (!full_m[d] || out_ready_s[d]);
      c   = 0;
      cv  = 1'b0;
      if (mode_of(d) == MODE_SEL) begin
        c  = (n == 2) ? int'(sel_s[d][0]) : int'(sel_s[d]);
        cv = (c < n) && in_valid_s[d][c[1:0]];
      end else begin
        for (int k = 1; k <= n; k++) begin
          if (!cv && in_valid_s[d][2'((last_m[d] + k) % n)]) begin
            cv = 1'b1;
            c  = (last_m[d] + k) % n;
          end
        end
      end
      er = (can && cv) ? (4'b0001 << c) : 4'b0000;
      check($sformatf("in_ready[%0d]", d), 32'(obs_ready[d]), 32'(er));
      acc_m[d] = er;
      if (can && cv) begin
        word = W'(in_data_s[d] >> (c * W));
        exp_q.push_back({4'(d), 4'(c), word});
        full_m[d] = 1'b1;
        if (mode_of(d) == MODE_RR) last_m[d] = c;
      end else if (rst_n && out_ready_s[d]) begin
        full_m[d] = 1'b0;
      end
    end
  endtask

  task automatic reset_check();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_out_valid[%0d]", d), 32'(obs_valid[d]), 32'd0);
      check($sformatf("rst_out_data[%0d]", d), 32'(obs_data[d]), 32'd0);
      check($sformatf("rst_grant[%0d]", d), 32'(obs_grant[d]), 32'd0);
      check($sformatf("rst_in_ready[%0d]", d), 32'(obs_ready[d]), 32'd0);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < ND; d++) begin
        if (rst_n && obs_valid[d]) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i][15:12] == 4'(d)) idx = i;
          end
          if (idx < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL word_unexpected[%0d]: got data %0h, expected no word", d, obs_data[d]);
          end else begin
            check($sformatf("out_data[%0d]", d), 32'(obs_data[d]), 32'(exp_q[idx][7:0]));
            check($sformatf("grant[%0d]", d), 32'(obs_grant[d]), 32'(exp_q[idx][11:8]));
            if (out_ready_s[d]) exp_q.delete(idx);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] rr_seq [5];
  logic [7:0] nd;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int d = 0; d < ND; d++) begin
      full_m[d] = 1'b0;
      last_m[d] = n_of(d) - 1;
      acc_m[d]  = 4'b0000;
    end
    rst_n = 1'b0;
    set_all(4'h0, 32'h0, 2'd0, 1'b0);
    repeat (2) begin @(negedge clk); eval(); end
    reset_check();

    // sel=2 with channel 2 holding A5
    @(negedge clk);
    rst_n = 1'b1;
    set_all(4'b0100, 32'h00A5_0000, 2'd2, 1'b1);
    eval();
    check("sel2_in_ready", 32'(obs_ready[0]), 32'h4);
    @(negedge clk);
    set_all(4'b0000, 32'h0, 2'd3, 1'b1);
    eval();
    check("sel2_out_data", 32'(obs_data[0]), 32'hA5);
    check("sel2_grant", 32'(obs_grant[0]), 32'd2);
    check("sel3_idle_ready", 32'(obs_ready[0]), 32'd0);
    // sel beyond the channel count on the 3-channel instance
    @(negedge clk);
    set_all(4'b0000, 32'h0, 2'd3, 1'b1);
    in_valid_s[3] = 4'b0111;
    in_data_s[3]  = 32'h0077_6655;
    eval();
    check("sel_ge_n_ready", 32'(obs_ready[3]), 32'd0);

    // backpressure: channel 1 holds 3C while the consumer stalls
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      set_all(4'b0010, 32'h0000_3C00, 2'd1, (t == 3));
      eval();
      check($sformatf("bp_in_ready_%0d", t), 32'(obs_ready[0]), (t == 0 || t == 3) ? 32'h2 : 32'h0);
      if (t > 0) check($sformatf("bp_out_data_%0d", t), 32'(obs_data[0]), 32'h3C);
    end

    // reset in the middle of traffic
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      set_all(4'hF, 32'h4433_2211 + 32'(t), 2'd0, 1'b1);
      eval();
    end
    #2;
    rst_n = 1'b0;
    #1;
    reset_check();
    @(negedge clk);
    eval();

    // round robin from reset, every channel requesting
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      set_all(4'hF, 32'hD4C3_B2A1 + 32'(t), 2'd0, 1'b1);
      eval();
      check($sformatf("rr_seq_%0d", t), 32'(obs_ready[1]), 32'(rr_seq[t]));
    end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      set_all(4'b1101, 32'h5A00_A55A + 32'(t), 2'd0, 1'b1);
      eval();
    end

    // streaming on channel 0, then idle cycles with and without out_ready
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      set_all(4'b0001, {24'h0, 8'($urandom)}, 2'd0, 1'b1);
      eval();
    end
    @(negedge clk); set_all(4'b0000, 32'h0, 2'd0, 1'b1); eval();
    @(negedge clk); set_all(4'b0000, 32'h0, 2'd0, 1'b0); eval();

    // random traffic; sources keep a pending word until it is taken
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < 4; c++) begin
          if (!(in_valid_s[d][c[1:0]] && !acc_m[d][c[1:0]])) begin
            in_valid_s[d][c[1:0]] = ($urandom_range(0, 99) < 60);
            nd = 8'($urandom);
            in_data_s[d] = (in_data_s[d] & ~(32'hFF << (c * W))) | (32'(nd) << (c * W));
          end
        end
        sel_s[d]       = 2'($urandom_range(0, 3));
        out_ready_s[d] = ($urandom_range(0, 99) < 70);
      end
      eval();
    end

    // drain
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      set_all(4'h0, 32'h0, 2'd0, 1'b1);
      eval();
    end
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
